// File: rtl/door_pkg.sv
// Shared types and elaboration helpers for the garage-door controller.
`timescale 1ns/1ps
package door_pkg;

  typedef enum logic [2:0] {
    UNKNOWN,
    OPENING,
    OPEN,
    CLOSING,
    CLOSED,
    DEAD,
    STOPPED,
    FAULT
  } door_state_t;

  typedef enum logic {
    DIR_UP,
    DIR_DOWN
  } door_dir_t;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/door_cycle_timer.sv
// Saturating cycle counter: clear wins over enable, holds at MAX-1 and flags it on done_o.
`timescale 1ns/1ps
module door_cycle_timer #(
  parameter int unsigned MAX = 2,
  parameter int unsigned W   = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count_o,
  output logic         done_o
);

  logic [W-1:0] count_q, count_d;

  assign done_o  = (count_q == W'(MAX - 1));
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !done_o) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fsm_door_ctrl_param.sv
// Garage-door controller: motor up/down with stop key, reversal dead-time, run timeout,
// fault latch and a blinking red lamp while the door is in motion.
`timescale 1ns/1ps
module fsm_door_ctrl_param
  import door_pkg::*;
#(
  parameter int unsigned DEAD_CYC    = 8,
  parameter int unsigned TIMEOUT_CYC = 2000000,
  parameter int unsigned BLINK_CYC   = 250000
) (
  input  logic clk2m,
  input  logic rst,
  input  logic key_up,
  input  logic key_down,
  input  logic key_stop,
  input  logic sense_up,
  input  logic sense_down,
  output logic ml,
  output logic mr,
  output logic light_red,
  output logic light_green,
  output logic fault
);

  localparam int unsigned MAX_CYC = max2(max2(DEAD_CYC, TIMEOUT_CYC), BLINK_CYC);
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
  localparam int unsigned RUN_MAX = max2(DEAD_CYC, TIMEOUT_CYC);

  door_state_t state_q, state_d;
  door_dir_t   dir_q, dir_d;
  logic        ml_q, ml_d, mr_q, mr_d;
  logic        light_red_q, light_red_d, light_green_q, light_green_d;
  logic        fault_q, fault_d;

  logic             kup, kdn;
  logic             moving_q, moving_d, enter_motion;
  logic [CNT_W-1:0] run_cnt, blink_cnt;
  logic             run_done, blink_done;
  logic             run_tmo, dead_exp;
  logic             run_clear, blink_clear, blink_en;

  // Conflicting direction keys cancel; stop masks both.
  assign kup = key_up   & ~key_down & ~key_stop;
  assign kdn = key_down & ~key_up   & ~key_stop;

  assign moving_q     = state_q inside {OPENING, CLOSING, DEAD};
  assign moving_d     = state_d inside {OPENING, CLOSING, DEAD};
  assign enter_motion = moving_d & ~moving_q;

  // One counter times both the run and the dead phase; it saturates at the larger
  // limit, so done also marks whichever limit coincides with it.
  assign run_clear = moving_d && (state_d != state_q);
  assign run_tmo   = run_done || (run_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign dead_exp  = run_done || (run_cnt == CNT_W'(DEAD_CYC - 1));

  door_cycle_timer #(.MAX(RUN_MAX), .W(CNT_W)) u_run_timer (
    .clk     (clk2m),
    .rst     (rst),
    .clear   (run_clear),
    .enable  (moving_q),
    .count_o (run_cnt),
    .done_o  (run_done)
  );

  assign blink_en    = moving_d & moving_q;
  assign blink_clear = enter_motion || (blink_cnt == CNT_W'(BLINK_CYC - 1));

  door_cycle_timer #(.MAX(BLINK_CYC), .W(CNT_W)) u_blink_timer (
    .clk     (clk2m),
    .rst     (rst),
    .clear   (blink_clear),
    .enable  (blink_en),
    .count_o (blink_cnt),
    .done_o  (blink_done)
  );

  // Next-state logic; both end-stops active is a sensor fault from any state.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    if (sense_up && sense_down) begin
      state_d = FAULT;
    end else begin
      case (state_q)
        UNKNOWN: begin
          if (sense_up)        state_d = OPEN;
          else if (sense_down) state_d = CLOSED;
          else if (kup)        state_d = OPENING;
          else if (kdn)        state_d = CLOSING;
        end
        OPENING: begin
          if (key_stop)      state_d = STOPPED;
          else if (sense_up) state_d = OPEN;
          else if (kdn) begin
            state_d = DEAD;
            dir_d   = DIR_DOWN;
          end else if (run_tmo) state_d = FAULT;
        end
        CLOSING: begin
          if (key_stop)        state_d = STOPPED;
          else if (sense_down) state_d = CLOSED;
          else if (kup) begin
            state_d = DEAD;
            dir_d   = DIR_UP;
          end else if (run_tmo) state_d = FAULT;
        end
        DEAD: begin
          if (key_stop)      state_d = STOPPED;
          else if (dead_exp) state_d = (dir_q == DIR_UP) ? OPENING : CLOSING;
        end
        OPEN:    if (kdn) state_d = CLOSING;
        CLOSED:  if (kup) state_d = OPENING;
        STOPPED: begin
          if (kup)      state_d = OPENING;
          else if (kdn) state_d = CLOSING;
        end
        FAULT:   if (key_stop) state_d = UNKNOWN;
        default: state_d = UNKNOWN;
      endcase
    end
  end

  // Output decode from the next state so outputs flop alongside the state register.
  always_comb begin
    ml_d          = (state_d == OPENING);
    mr_d          = (state_d == CLOSING);
    light_green_d = (state_d == OPEN);
    fault_d       = (state_d == FAULT);
    light_red_d   = 1'b0;
    case (state_d)
      CLOSED, FAULT: light_red_d = 1'b1;
      OPENING, CLOSING, DEAD: begin
        if (enter_motion)    light_red_d = 1'b1;
        else if (blink_done) light_red_d = ~light_red_q;
        else                 light_red_d = light_red_q;
      end
      default: light_red_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk2m or posedge rst) begin
    if (rst) begin
      state_q       <= UNKNOWN;
      dir_q         <= DIR_UP;
      ml_q          <= 1'b0;
      mr_q          <= 1'b0;
      light_red_q   <= 1'b0;
      light_green_q <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      dir_q         <= dir_d;
      ml_q          <= ml_d;
      mr_q          <= mr_d;
      light_red_q   <= light_red_d;
      light_green_q <= light_green_d;
      fault_q       <= fault_d;
    end
  end

  assign ml          = ml_q;
  assign mr          = mr_q;
  assign light_red   = light_red_q;
  assign light_green = light_green_q;
  assign fault       = fault_q;

endmodule
